// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single data_memory block port between two cache requesters:
//   requester 0 : instruction-cache refill path
//   requester 1 : data-cache write-back / refill path
//
// The arbiter runs one whole-block transaction (read or write) at a time. It
// drives the memory port and holds it stable for MEM_LATENCY cycles. It then
// returns the read block on rblock and gives the granted requester a
// one-cycle done pulse. When both requesters ask in the same idle cycle, the
// one not served last wins (round-robin).
//
// Ports
//   clk, rst                    clock (posedge), synchronous active-high reset
//   req0/we0/addr0/wblock0      requester 0 request level, write flag,
//                               word address, write block
//   done0                       requester 0 one-cycle completion pulse
//   req1/we1/addr1/wblock1      requester 1, same meaning
//   done1                       requester 1 one-cycle completion pulse
//   rblock                      block returned by the last completed read
//   mem_ptr                     block-aligned memory address
//   mem_wblock                  memory write data
//   mem_we                      memory write enable (first ACCESS cycle only)
//   mem_rblock                  memory read data
//   busy                        high while a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WORD_SIZE   = 32,
   parameter int BLOCK_SIZE  = 16,
   parameter int MEM_LATENCY = 3
) (
   input  logic                            clk,
   input  logic                            rst,

   input  logic                            req0,
   input  logic                            we0,
   input  logic [WORD_SIZE-1:0]            addr0,
   input  logic [WORD_SIZE*BLOCK_SIZE-1:0] wblock0,
   output logic                            done0,

   input  logic                            req1,
   input  logic                            we1,
   input  logic [WORD_SIZE-1:0]            addr1,
   input  logic [WORD_SIZE*BLOCK_SIZE-1:0] wblock1,
   output logic                            done1,

   output logic [WORD_SIZE*BLOCK_SIZE-1:0] rblock,
   output logic [WORD_SIZE-1:0]            mem_ptr,
   output logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_wblock,
   output logic                            mem_we,
   input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_rblock,
   output logic                            busy
);

   localparam int BLK_W = WORD_SIZE * BLOCK_SIZE;

   // Counter must be able to hold MEM_LATENCY itself.
   localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

   // BLOCK_SIZE is a power of two; clearing the word-offset bits gives the
   // block base address.
   localparam logic [WORD_SIZE-1:0] BLK_MASK =
      ~(WORD_SIZE'(BLOCK_SIZE) - WORD_SIZE'(1));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             last_grant;   // requester served most recently
   logic             grant;        // requester owning the current transaction
   logic             txn_we;       // latched write flag of the current transaction

   // Requester selection for an idle cycle
   logic                 sel;
   logic                 sel_we;
   logic [WORD_SIZE-1:0] sel_addr;
   logic [BLK_W-1:0]     sel_wblock;

   // Requester 1 wins when it is alone, or when both ask and requester 0
   // was the one served last.
   always_comb begin
      sel        = req1 & (~req0 | ~last_grant);
      sel_we     = sel ? we1     : we0;
      sel_addr   = sel ? addr1   : addr0;
      sel_wblock = sel ? wblock1 : wblock0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         txn_we     <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         mem_we     <= 1'b0;
         busy       <= 1'b0;
         mem_ptr    <= '0;
         mem_wblock <= '0;
         rblock     <= '0;
      end else begin
         // Pulsed outputs default low; each state raises them when needed.
         done0  <= 1'b0;
         done1  <= 1'b0;
         mem_we <= 1'b0;

         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant      <= sel;
                  last_grant <= sel;
                  txn_we     <= sel_we;
                  // Port registers are loaded once here and not touched
                  // again until the next grant, so requester changes after
                  // the grant cannot reach the memory.
                  mem_ptr    <= sel_addr & BLK_MASK;
                  mem_wblock <= sel_wblock;
                  mem_we     <= sel_we;
                  count      <= CNT_W'(1);
                  busy       <= 1'b1;
                  state      <= ACCESS;
               end
            end

            ACCESS: begin
               count <= count + 1'b1;
               if (count == LAT) begin
                  if (!txn_we) begin
                     rblock <= mem_rblock;
                  end
                  done0 <= ~grant;
                  done1 <= grant;
                  state <= DONE;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A transaction-level reference model runs every
// cycle on the falling edge. It keeps a schedule of the current grant and
// derives the expected port outputs from the cycle offset into that grant.
// Scenario tasks drive the stimulus and check the key events of each
// scenario at fixed cycle offsets.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int W  = 32;
   localparam int BS = 16;
   localparam int L  = 3;
   localparam int BW = W * BS;
   localparam logic [W-1:0] MASK = ~(W'(BS) - W'(1));

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [W-1:0]  addr0 = '0, addr1 = '0;
   logic [BW-1:0] wblock0 = '0, wblock1 = '0, mem_rblock = '0;
   logic          done0, done1, mem_we, busy;
   logic [BW-1:0] rblock, mem_wblock;
   logic [W-1:0]  mem_ptr;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.WORD_SIZE(W), .BLOCK_SIZE(BS), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wblock0(wblock0), .done0(done0),
      .req1(req1), .we1(we1), .addr1(addr1), .wblock1(wblock1), .done1(done1),
      .rblock(rblock), .mem_ptr(mem_ptr), .mem_wblock(mem_wblock),
      .mem_we(mem_we), .mem_rblock(mem_rblock), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [BW-1:0] rand_block();
      logic [BW-1:0] b;
      for (int i = 0; i < BS; i++) b[i*W +: W] = $urandom;
      return b;
   endfunction

   // ---------------- transaction-level reference model ----------------
   int            cyc     = 0;
   bit            m_act   = 0;
   int            m_start = 0;
   bit            m_who   = 0;
   bit            m_we    = 0;
   bit            m_last  = 1;
   int            m_free  = 0;
   logic [W-1:0]  m_ptr   = '0;
   logic [BW-1:0] m_wb    = '0;
   logic [BW-1:0] m_rb    = '0;

   always @(negedge clk) begin
      int   k;
      bit   who;
      logic e_busy, e_we, e_d0, e_d1;
      k      = cyc - m_start;
      e_busy = m_act && k >= 1 && k <= L + 1;
      e_we   = m_act && k == 1 && m_we;
      e_d0   = m_act && k == L + 1 && !m_who;
      e_d1   = m_act && k == L + 1 && m_who;

      checks++;
      if (busy !== e_busy) begin
         errors++; $display("FAIL model_busy cyc=%0d got %b exp %b", cyc, busy, e_busy);
      end
      checks++;
      if (mem_we !== e_we) begin
         errors++; $display("FAIL model_mem_we cyc=%0d got %b exp %b", cyc, mem_we, e_we);
      end
      checks++;
      if (done0 !== e_d0) begin
         errors++; $display("FAIL model_done0 cyc=%0d got %b exp %b", cyc, done0, e_d0);
      end
      checks++;
      if (done1 !== e_d1) begin
         errors++; $display("FAIL model_done1 cyc=%0d got %b exp %b", cyc, done1, e_d1);
      end
      checks++;
      if (mem_ptr !== m_ptr) begin
         errors++; $display("FAIL model_mem_ptr cyc=%0d got %h exp %h", cyc, mem_ptr, m_ptr);
      end
      checks++;
      if (mem_wblock !== m_wb) begin
         errors++; $display("FAIL model_mem_wblock cyc=%0d got %h exp %h", cyc, mem_wblock, m_wb);
      end
      checks++;
      if (rblock !== m_rb) begin
         errors++; $display("FAIL model_rblock cyc=%0d got %h exp %h", cyc, rblock, m_rb);
      end

      // Advance the model with this cycle's inputs.
      if (rst) begin
         m_act  = 0;
         m_last = 1;
         m_ptr  = '0;
         m_wb   = '0;
         m_rb   = '0;
         m_free = cyc + 1;
      end else begin
         if (m_act && !m_we && k == L) m_rb = mem_rblock;
         if (cyc >= m_free && (req0 || req1)) begin
            who     = (req0 && req1) ? !m_last : req1;
            m_who   = who;
            m_last  = who;
            m_we    = who ? we1 : we0;
            m_ptr   = (who ? addr1 : addr0) & MASK;
            m_wb    = who ? wblock1 : wblock0;
            m_act   = 1;
            m_start = cyc;
            m_free  = cyc + L + 2;
         end
      end
      cyc++;
   end

   // ---------------- scenarios ----------------
   logic [BW-1:0] last_read;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b we=%b d0=%b d1=%b exp all 0", busy, mem_we, done0, done1);
      end
      checks++;
      if (mem_ptr !== '0 || rblock !== '0 || mem_wblock !== '0) begin
         errors++;
         $display("FAIL reset_data got ptr=%h rblock_nonzero=%b wblock_nonzero=%b exp 0",
                  mem_ptr, |rblock, |mem_wblock);
      end
   endtask

   task automatic test_single_read();
      logic [BW-1:0] a;
      a          = rand_block();
      mem_rblock = a;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0123; wblock0 = rand_block();
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         if (k <= 3) begin
            checks++;
            if (mem_ptr !== 32'h0000_0120) begin
               errors++; $display("FAIL read_ptr k=%0d got %h exp 00000120", k, mem_ptr);
            end
         end
         checks++;
         if (mem_we !== 1'b0) begin
            errors++; $display("FAIL read_we k=%0d got %b exp 0", k, mem_we);
         end
         checks++;
         if (done0 !== (k == 4)) begin
            errors++; $display("FAIL read_done0 k=%0d got %b exp %b", k, done0, (k == 4));
         end
         if (k == 4) begin
            checks++;
            if (rblock !== a) begin
               errors++; $display("FAIL read_rblock got %h exp %h", rblock, a);
            end
            req0 = 1'b0;
         end
         if (k == 5) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++; $display("FAIL read_busy_end got %b exp 0", busy);
            end
         end
      end
      last_read = a;
   endtask

   task automatic test_single_write();
      logic [BW-1:0] b;
      b          = rand_block();
      mem_rblock = rand_block();
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_4010; wblock1 = b;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         checks++;
         if (mem_we !== (k == 1)) begin
            errors++; $display("FAIL write_we k=%0d got %b exp %b", k, mem_we, (k == 1));
         end
         if (k <= 3) begin
            checks++;
            if (mem_ptr !== 32'h0000_4010 || mem_wblock !== b) begin
               errors++; $display("FAIL write_port k=%0d got ptr %h exp 00004010 (wblock ok=%b)",
                                  k, mem_ptr, mem_wblock === b);
            end
         end
         checks++;
         if (done1 !== (k == 4) || done0 !== 1'b0) begin
            errors++; $display("FAIL write_done k=%0d got d1=%b d0=%b exp d1=%b d0=0",
                               k, done1, done0, (k == 4));
         end
         checks++;
         if (rblock !== last_read) begin
            errors++; $display("FAIL write_rblock_kept k=%0d got %h exp %h", k, rblock, last_read);
         end
         if (k == 4) req1 = 1'b0;
      end
   endtask

   task automatic test_tie_alternation();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = $urandom;
      req1 = 1'b1; we1 = 1'b0; addr1 = $urandom;
      for (int k = 1; k <= 15; k++) begin
         next_cycle();
         checks++;
         if (done0 !== (k == 4 || k == 14) || done1 !== (k == 9)) begin
            errors++; $display("FAIL tie_done k=%0d got d0=%b d1=%b exp d0=%b d1=%b",
                               k, done0, done1, (k == 4 || k == 14), (k == 9));
         end
         if (k == 4) req0 = 1'b0;
         if (k == 9) req1 = 1'b0;
         if (k == 10) begin
            req0 = 1'b1; req1 = 1'b1;
         end
         if (k == 14) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
   endtask

   task automatic test_hold_and_wait();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0500;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         if (k <= 3) begin
            checks++;
            if (mem_ptr !== 32'h0000_0500) begin
               errors++; $display("FAIL hold_ptr0 k=%0d got %h exp 00000500", k, mem_ptr);
            end
         end
         if (k >= 6 && k <= 8) begin
            checks++;
            if (mem_ptr !== 32'h0000_0800) begin
               errors++; $display("FAIL hold_ptr1 k=%0d got %h exp 00000800", k, mem_ptr);
            end
         end
         checks++;
         if (done0 !== (k == 4) || done1 !== (k == 9)) begin
            errors++; $display("FAIL hold_done k=%0d got d0=%b d1=%b exp d0=%b d1=%b",
                               k, done0, done1, (k == 4), (k == 9));
         end
         if (k == 1) begin
            req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0800;
         end
         if (k == 2) addr0 = 32'h0000_9990;
         if (k == 4) req0 = 1'b0;
         if (k == 9) req1 = 1'b0;
      end
   endtask

   task automatic test_reset_mid_write();
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_4040; wblock1 = rand_block();
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         if (k == 1) begin
            checks++;
            if (mem_we !== 1'b1) begin
               errors++; $display("FAIL rstmid_we_first got %b exp 1", mem_we);
            end
         end
         if (k == 2) rst = 1'b1;
         if (k == 3) begin
            checks++;
            if (mem_we !== 1'b0 || busy !== 1'b0 || mem_ptr !== '0) begin
               errors++; $display("FAIL rstmid_state got we=%b busy=%b ptr=%h exp 0 0 0",
                                  mem_we, busy, mem_ptr);
            end
            rst = 1'b0;
            req0 = 1'b1; we0 = 1'b0; addr0 = $urandom;
            we1  = 1'b0;
         end
         if (k >= 3) begin
            checks++;
            if (done0 !== (k == 7) || done1 !== 1'b0) begin
               errors++; $display("FAIL rstmid_done k=%0d got d0=%b d1=%b exp d0=%b d1=0",
                                  k, done0, done1, (k == 7));
            end
         end
         if (k == 7) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
   endtask

   task automatic test_early_drop();
      mem_rblock = rand_block();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0AB7;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         if (k == 2) req0 = 1'b0;
         checks++;
         if (done0 !== (k == 4)) begin
            errors++; $display("FAIL early_drop_done0 k=%0d got %b exp %b", k, done0, (k == 4));
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 2000; n++) begin
         next_cycle();
         mem_rblock = rand_block();
         rst = ($urandom_range(0, 149) == 0);
         if (done0) req0 = 1'b0;
         else if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; we0 = $urandom; addr0 = $urandom; wblock0 = rand_block();
         end
         if (done1) req1 = 1'b0;
         else if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; we1 = $urandom; addr1 = $urandom; wblock1 = rand_block();
         end
      end
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (L + 4) next_cycle();
   endtask

   initial begin
      last_read = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_single_read();
      test_single_write();
      test_tie_alternation();
      test_hold_and_wait();
      test_reset_mid_write();
      test_early_drop();
      test_random();
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
